buzzer_arbiter: RTL and testbench
=================================

// Module: buzzer_arbiter
// PURPOSE
// Owns the single piezo buzzer pin of the keypad lock. Arbitrates three tone requesters:
// key click, unlock success and wrong-code fail. Sequences each tone's square wave and
// duration, so the keypad/password logic only issues one-cycle request pulses.
// Sits between the password controller and the board buzzer pin.
// PARAMETERS
// CLICK_HALF  50000     half-period of click tone, clk cycles (>=1)
// CLICK_LEN   10000000  click tone duration, clk cycles (>=1)
// OK_HALF     25000     half-period of success tone
// OK_LEN      30000000  success tone duration
// ERR_HALF    100000    half-period of fail tone
// ERR_LEN     15000000  fail tone duration
// ERR_GAP_LO  5000000   fail tone silent window start (len_cnt, inclusive)
// ERR_GAP_HI  10000000  fail tone silent window end (len_cnt, exclusive); GAP_LO<=GAP_HI<=ERR_LEN
// PORTS
// clk       in   1  system clock
// rst       in   1  asynchronous, active-high reset
// req_click in   1  one-cycle pulse: key press click
// req_ok    in   1  one-cycle pulse: correct code
// req_err   in   1  one-cycle pulse: wrong code
// mute      in   1  level; forces buzzer low, sequencing continues
// buzzer    out  1  registered square-wave drive to buzzer pin
// busy      out  1  high while any tone active (state != IDLE)
// cur_src   out  2  00 idle, 01 click, 10 ok, 11 err
// done      out  1  one-cycle pulse when a tone ends by expiry (not on preemption)
// BEHAVIOUR
// - Reset (any time, incl. mid-tone): state IDLE, buzzer=0, busy=0, cur_src=00, done=0, counters=0, phase=0.
// - FSM: IDLE, CLICK, OK, ERR. Priority ERR > OK > CLICK; simultaneous requests -> highest wins, others dropped.
// - Acceptance: a request is accepted if its class >= current class (IDLE lowest). Lower-class requests are
//   dropped, no queue. Same class restarts the tone; higher class preempts, no done pulse.
// - On the acceptance edge E0: state<=class, phase<=1, len_cnt<=0, half_cnt<=0, buzzer<=~mute.
// - Each later edge while active with no new acceptance: len_cnt+1. If half_cnt==HALF-1, then half_cnt<=0 and
//   phase toggles; else half_cnt+1. Tone is high HALF cycles, then low HALF cycles.
// - buzzer <= phase_next & ~mute & ~gap, where gap = (state==ERR) && ERR_GAP_LO<=len_cnt_next<ERR_GAP_HI.
// - Expiry: at the edge where len_cnt==LEN-1: state<=IDLE, buzzer<=0, counters<=0, done<=1 for one cycle.
//   The tone spans exactly LEN cycles from E0.
// - A request arriving on the expiry edge is accepted as from IDLE. The new tone starts at E0 and done still pulses.
// - busy/cur_src are registered with state. In IDLE, buzzer is held 0.
// - Counters are 32-bit unsigned. No wrap occurs because len_cnt resets at LEN-1.
// TESTING (bench params: CLICK_HALF=2 CLICK_LEN=8 OK_HALF=1 OK_LEN=6 ERR_HALF=2 ERR_LEN=12 GAP 4..8)
// 1 req_click pulse -> buzzer 1,1,0,0,1,1,0,0 over 8 cycles; done pulses at cycle 9; busy high cycles 1-8.
// 2 req_err pulse -> buzzer high only at len_cnt 0,1,8,9; cur_src=11 for 12 cycles; done once.
// 3 req_click, then req_ok at len_cnt=3 -> restart as OK (buzzer 1,0,1,0,1,0), cur_src 01->10, no done for click.
// 4 req_click+req_ok+req_err same cycle -> ERR tone only. req_click during ERR -> ignored, ERR length unchanged.
// 5 req_ok at len_cnt=3 of OK -> restarts; total busy = 4+6 cycles. mute high throughout -> buzzer 0, done still pulses.
// 6 rst asserted mid-OK tone -> buzzer/busy/cur_src 0 immediately. After release, IDLE with no spurious done.

Source files
------------

// File: rtl/buzzer_arbiter.sv
// Purpose: arbitrates click/ok/err tone requests onto one buzzer pin, sequencing square wave and duration.
// Latency: a request is accepted on the next clk edge; buzzer, busy, cur_src and done are all registered.
// Backpressure: none; lower-class requests are dropped, same or higher class restarts or preempts the tone.
module buzzer_arbiter #(
  parameter int unsigned CLICK_HALF = 50000,
  parameter int unsigned CLICK_LEN  = 10000000,
  parameter int unsigned OK_HALF    = 25000,
  parameter int unsigned OK_LEN     = 30000000,
  parameter int unsigned ERR_HALF   = 100000,
  parameter int unsigned ERR_LEN    = 15000000,
  parameter int unsigned ERR_GAP_LO = 5000000,
  parameter int unsigned ERR_GAP_HI = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_click,
  input  logic       req_ok,
  input  logic       req_err,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] cur_src,
  output logic       done
);

  // Encoding doubles as the priority class and the cur_src code.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLICK = 2'b01,
    OK    = 2'b10,
    ERR   = 2'b11
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] len_cnt, len_nxt;
  logic [31:0] half_cnt, half_nxt;
  logic        phase, phase_nxt;
  logic        buzzer_nxt, done_nxt;
  logic [31:0] cur_half, cur_len;
  logic [1:0]  req_cls;
  logic [1:0]  floor_cls;
  logic        expire, accept, gap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len_cnt  <= '0;
      half_cnt <= '0;
      phase    <= 1'b0;
      buzzer   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      len_cnt  <= len_nxt;
      half_cnt <= half_nxt;
      phase    <= phase_nxt;
      buzzer   <= buzzer_nxt;
      done     <= done_nxt;
    end
  end

  assign busy    = (state != IDLE);
  assign cur_src = state;

  always_comb begin
    cur_half = 32'd1;
    cur_len  = 32'd1;
    case (state)
      CLICK:   begin cur_half = CLICK_HALF; cur_len = CLICK_LEN; end
      OK:      begin cur_half = OK_HALF;    cur_len = OK_LEN;    end
      ERR:     begin cur_half = ERR_HALF;   cur_len = ERR_LEN;   end
      default: begin cur_half = 32'd1;      cur_len = 32'd1;     end
    endcase
  end

  always_comb begin
    state_nxt  = state;
    len_nxt    = len_cnt;
    half_nxt   = half_cnt;
    phase_nxt  = phase;
    buzzer_nxt = 1'b0;
    done_nxt   = 1'b0;
    gap        = 1'b0;

    req_cls = req_err ? 2'b11 : req_ok ? 2'b10 : req_click ? 2'b01 : 2'b00;
    expire  = (state != IDLE) && (len_cnt == cur_len - 32'd1);
    // On the expiry edge a new request competes as if the arbiter were already idle.
    floor_cls = expire ? 2'b00 : state;
    accept    = (req_cls != 2'b00) && (req_cls >= floor_cls);

    if (accept) begin
      state_nxt  = state_t'(req_cls);
      phase_nxt  = 1'b1;
      len_nxt    = '0;
      half_nxt   = '0;
      buzzer_nxt = ~mute;
      done_nxt   = expire;
    end else if (expire) begin
      state_nxt = IDLE;
      len_nxt   = '0;
      half_nxt  = '0;
      phase_nxt = 1'b0;
      done_nxt  = 1'b1;
    end else if (state != IDLE) begin
      len_nxt = len_cnt + 32'd1;
      if (half_cnt == cur_half - 32'd1) begin
        half_nxt  = '0;
        phase_nxt = ~phase;
      end else begin
        half_nxt = half_cnt + 32'd1;
      end
      gap        = (state == ERR) && (len_nxt >= ERR_GAP_LO) && (len_nxt < ERR_GAP_HI);
      buzzer_nxt = phase_nxt & ~mute & ~gap;
    end
  end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Drives directed and random tone requests into buzzer_arbiter and compares every output
// each cycle against a tone-offset model of the arbiter.
module tb_buzzer_arbiter;

  localparam int CH = 2, CL = 8, OH = 1, OL = 6, EH = 2, EL = 12, GLO = 4, GHI = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_click = 1'b0, req_ok = 1'b0, req_err = 1'b0, mute = 1'b0;
  logic       buzzer, busy, done;
  logic [1:0] cur_src;

  int n_vec = 0;
  int n_bad = 0;

  // Model: active class (0 idle) and offset of the current cycle from the tone's start edge.
  int m_cls = 0;
  int m_k   = 0;
  bit m_buz = 1'b0;
  bit m_done = 1'b0;

  buzzer_arbiter #(
    .CLICK_HALF(CH), .CLICK_LEN(CL), .OK_HALF(OH), .OK_LEN(OL),
    .ERR_HALF(EH), .ERR_LEN(EL), .ERR_GAP_LO(GLO), .ERR_GAP_HI(GHI)
  ) dut (
    .clk(clk), .rst(rst), .req_click(req_click), .req_ok(req_ok), .req_err(req_err),
    .mute(mute), .buzzer(buzzer), .busy(busy), .cur_src(cur_src), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int half_of(input int c);
    return (c == 1) ? CH : (c == 2) ? OH : EH;
  endfunction

  function automatic int len_of(input int c);
    return (c == 1) ? CL : (c == 2) ? OL : EL;
  endfunction

  task automatic model_step(input bit c, input bit o, input bit e, input bit mu);
    int r;
    r = e ? 3 : o ? 2 : c ? 1 : 0;
    m_done = 1'b0;
    if (m_cls != 0 && m_k == len_of(m_cls) - 1) begin
      m_done = 1'b1;
      m_cls  = 0;
      m_k    = 0;
    end else if (m_cls != 0) begin
      m_k++;
    end
    if (r != 0 && r >= m_cls) begin
      m_cls = r;
      m_k   = 0;
    end
    m_buz = (m_cls != 0) && (((m_k / half_of(m_cls)) % 2) == 0) && !mu &&
            !(m_cls == 3 && m_k >= GLO && m_k < GHI);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".buzzer"}, 32'(buzzer), 32'(m_buz));
    check_eq({tag, ".busy"}, 32'(busy), 32'(m_cls != 0));
    check_eq({tag, ".cur_src"}, 32'(cur_src), 32'(m_cls));
    check_eq({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  // Apply inputs for one clock, step the model on the edge, check at the following negedge.
  task automatic cyc(input bit c, input bit o, input bit e, input bit mu, input string tag);
    req_click = c; req_ok = o; req_err = e; mute = mu;
    @(posedge clk);
    model_step(c, o, e, mu);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_cycles(input int n, input bit mu, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, mu, tag);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    m_cls = 0; m_k = 0; m_buz = 1'b0; m_done = 1'b0;
    check_all({tag, ".async"});
    req_click = 1'b0; req_ok = 1'b0; req_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all({tag, ".held"});
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    idle_cycles(2, 1'b0, "idle");

    // Single click tone, then ERR tone with its silent window.
    cyc(1, 0, 0, 0, "click");
    idle_cycles(10, 1'b0, "click");
    cyc(0, 0, 1, 0, "err");
    idle_cycles(14, 1'b0, "err");

    // Click preempted by ok at len_cnt 3.
    cyc(1, 0, 0, 0, "preempt");
    idle_cycles(3, 1'b0, "preempt");
    cyc(0, 1, 0, 0, "preempt");
    idle_cycles(8, 1'b0, "preempt");

    // All three at once, then a click during ERR that must be ignored.
    cyc(1, 1, 1, 0, "triple");
    idle_cycles(3, 1'b0, "triple");
    cyc(1, 0, 0, 0, "triple");
    idle_cycles(10, 1'b0, "triple");

    // OK restarted by OK, muted throughout.
    cyc(0, 1, 0, 1, "restart");
    idle_cycles(3, 1'b1, "restart");
    cyc(0, 1, 0, 1, "restart");
    idle_cycles(8, 1'b1, "restart");

    // Request landing exactly on the click expiry edge.
    cyc(1, 0, 0, 0, "chain");
    idle_cycles(7, 1'b0, "chain");
    cyc(1, 0, 0, 0, "chain");
    idle_cycles(10, 1'b0, "chain");

    // Reset in the middle of an OK tone.
    cyc(0, 1, 0, 0, "rstmid");
    idle_cycles(2, 1'b0, "rstmid");
    do_reset("rstmid");
    idle_cycles(8, 1'b0, "rstmid");

    // Random traffic with occasional mute and resets.
    for (int i = 0; i < 3000; i++) begin
      bit c, o, e, mu;
      c  = ($urandom_range(0, 5) == 0);
      o  = ($urandom_range(0, 11) == 0);
      e  = ($urandom_range(0, 17) == 0);
      mu = ($urandom_range(0, 7) == 0);
      cyc(c, o, e, mu, "rand");
      if ($urandom_range(0, 299) == 0) do_reset("randrst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
